seg_scan_reader: RTL and testbench

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

---
 rtl/seg_scan_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers a 4-digit value by watching a multiplexed,
// active-low 7-segment display bus. Each digit must be observed stable for
// STABLE_CNT cycles before it is captured; once all four slots are captured
// the frame is published with a one-cycle valid pulse. A partial frame that
// stalls for TIMEOUT cycles is dropped with a one-cycle timeout pulse.
module seg_scan_reader #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  bcn,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        valid,
  output logic        timeout
);

  localparam logic [7:0]  LP_STAB      = 8'(STABLE_CNT);
  localparam logic [7:0]  LP_STAB_LAST = 8'(STABLE_CNT - 1);
  localparam logic [15:0] LP_IDLE_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [10:0] r_prev;
  logic [7:0]  r_stab;
  logic [15:0] r_idle;
  logic [3:0]  r_seen;

  logic [3:0][3:0] r_sh_val;
  logic [3:0]      r_sh_blank;
  logic [3:0]      r_sh_err;

  logic [15:0] r_digits;
  logic [3:0]  r_blank;
  logic [3:0]  r_err;
  logic        r_valid;
  logic        r_timeout;

  logic [10:0] w_sample;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [7:0]  w_stab_nxt;
  logic        w_capture;
  logic [3:0]  w_dec_val;
  logic        w_dec_blank;
  logic        w_dec_err;
  logic [3:0]  w_seen_upd;
  logic        w_complete;
  logic        w_to_hit;
  logic [3:0]  w_seen_nxt;
  logic [15:0] w_idle_nxt;

  logic [3:0][3:0] w_sh_val_nxt;
  logic [3:0]      w_sh_blank_nxt;
  logic [3:0]      w_sh_err_nxt;

  assign w_sample = {an, bcn};

  // Classify the digit select: exactly one low bit selects a slot.
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  // Stability counter next value and the single-shot capture strobe.
  always_comb begin
    w_stab_nxt = r_stab;
    if (!w_onehot) begin
      w_stab_nxt = '0;
    end else if (w_sample != r_prev) begin
      w_stab_nxt = 8'd1;
    end else if (r_stab != LP_STAB) begin
      w_stab_nxt = r_stab + 8'd1;
    end
  end

  // Capture fires only on the STABLE_CNT-1 -> STABLE_CNT step, never while saturated.
  assign w_capture = w_onehot && (w_sample == r_prev) && (r_stab == LP_STAB_LAST);

  // Segment pattern decoder (active-low, bit6=a .. bit0=g).
  always_comb begin
    w_dec_val   = 4'hE;
    w_dec_blank = 1'b0;
    w_dec_err   = 1'b0;
    case (bcn)
      7'b0000001: w_dec_val = 4'd0;
      7'b1001111: w_dec_val = 4'd1;
      7'b0010010: w_dec_val = 4'd2;
      7'b0000110: w_dec_val = 4'd3;
      7'b1001100: w_dec_val = 4'd4;
      7'b0100100: w_dec_val = 4'd5;
      7'b0100000: w_dec_val = 4'd6;
      7'b0001111: w_dec_val = 4'd7;
      7'b0000000: w_dec_val = 4'd8;
      7'b0000100: w_dec_val = 4'd9;
      7'b1111111: begin
        w_dec_val   = 4'hF;
        w_dec_blank = 1'b1;
      end
      default: begin
        w_dec_val = 4'hE;
        w_dec_err = 1'b1;
      end
    endcase
  end

  // Shadow slot update; the completed frame includes the capture of this cycle.
  always_comb begin
    w_sh_val_nxt   = r_sh_val;
    w_sh_blank_nxt = r_sh_blank;
    w_sh_err_nxt   = r_sh_err;
    w_seen_upd     = r_seen;
    if (w_capture) begin
      w_sh_val_nxt[w_idx]   = w_dec_val;
      w_sh_blank_nxt[w_idx] = w_dec_blank;
      w_sh_err_nxt[w_idx]   = w_dec_err;
      w_seen_upd            = r_seen | (4'b0001 << w_idx);
    end
  end

  assign w_complete = w_capture && (w_seen_upd == 4'hF);

  // A capture in the limit cycle takes priority over the timeout.
  assign w_to_hit = (r_state == S_COLLECT) && !w_capture && (r_idle == LP_IDLE_LAST);

  // Next-state logic plus seen mask and idle counter.
  always_comb begin
    w_state_nxt = r_state;
    w_seen_nxt  = r_seen;
    w_idle_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_state_nxt = S_COLLECT;
          w_seen_nxt  = w_seen_upd;
        end
      end
      S_COLLECT: begin
        if (w_complete) begin
          w_state_nxt = S_IDLE;
          w_seen_nxt  = '0;
        end else if (w_capture) begin
          w_seen_nxt  = w_seen_upd;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_seen_nxt  = '0;
        end else begin
          w_idle_nxt  = r_idle + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_seen_nxt  = '0;
      end
    endcase
  end

  // Previous-sample register and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= {4'hF, 7'h7F};
      r_stab <= '0;
    end else begin
      r_prev <= w_sample;
      r_stab <= w_stab_nxt;
    end
  end

  // FSM state, seen mask, idle counter and shadow slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_seen     <= '0;
      r_idle     <= '0;
      r_sh_val   <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_seen     <= w_seen_nxt;
      r_idle     <= w_idle_nxt;
      r_sh_val   <= w_sh_val_nxt;
      r_sh_blank <= w_sh_blank_nxt;
      r_sh_err   <= w_sh_err_nxt;
    end
  end

  // Published frame and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits  <= '0;
      r_blank   <= '0;
      r_err     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= w_complete;
      r_timeout <= w_to_hit;
      if (w_complete) begin
        r_digits <= w_sh_val_nxt;
        r_blank  <= w_sh_blank_nxt;
        r_err    <= w_sh_err_nxt;
      end
    end
  end

  assign digits  = r_digits;
  assign blank   = r_blank;
  assign err     = r_err;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader with STABLE_CNT=4, TIMEOUT=16.
// Each table row holds one {an,bcn} sample for a number of cycles; pulses are
// counted during the row and the published frame is checked at its end.
module tb_seg_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  bcn = 7'h7F;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        valid;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] B0  = 7'b0000001;
  localparam logic [6:0] B1  = 7'b1001111;
  localparam logic [6:0] B2  = 7'b0010010;
  localparam logic [6:0] B3  = 7'b0000110;
  localparam logic [6:0] B4  = 7'b1001100;
  localparam logic [6:0] B5  = 7'b0100100;
  localparam logic [6:0] B6  = 7'b0100000;
  localparam logic [6:0] B7  = 7'b0001111;
  localparam logic [6:0] B8  = 7'b0000000;
  localparam logic [6:0] B9  = 7'b0000100;
  localparam logic [6:0] BBL = 7'b1111111;
  localparam logic [6:0] BER = 7'b1010101;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  bcn;
    int          ncyc;
    int          ev;
    int          et;
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
  } vec_t;

  vec_t tbl [23];

  seg_scan_reader #(
    .STABLE_CNT (4),
    .TIMEOUT    (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .an      (an),
    .bcn     (bcn),
    .digits  (digits),
    .blank   (blank),
    .err     (err),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold one sample for n cycles, counting valid/timeout pulses seen after each edge.
  task automatic seg(input logic [3:0] a, input logic [6:0] b, input int n,
                     output int nv, output int nt);
    nv = 0;
    nt = 0;
    for (int k = 0; k < n; k++) begin
      an  = a;
      bcn = b;
      @(posedge clk);
      #1;
      nv += int'(valid);
      nt += int'(timeout);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic [3:0] b,
                         input logic [3:0] e);
    chk({tag, ".digits"}, digits, d);
    chk({tag, ".blank"}, {12'h0, blank}, {12'h0, b});
    chk({tag, ".err"}, {12'h0, err}, {12'h0, e});
  endtask

  initial begin
    int nv, nt, av, at;

    // frame 4321
    tbl[0]  = '{4'hF, BBL, 3,  0, 0, 16'h0000, 4'h0, 4'h0};
    tbl[1]  = '{4'hE, B1,  4,  0, 0, 16'h0000, 4'h0, 4'h0};
    tbl[2]  = '{4'hD, B2,  4,  0, 0, 16'h0000, 4'h0, 4'h0};
    tbl[3]  = '{4'hB, B3,  4,  0, 0, 16'h0000, 4'h0, 4'h0};
    tbl[4]  = '{4'h7, B4,  4,  1, 0, 16'h4321, 4'h0, 4'h0};
    // blank and undecodable digits
    tbl[5]  = '{4'hE, B1,  4,  0, 0, 16'h4321, 4'h0, 4'h0};
    tbl[6]  = '{4'hD, B2,  4,  0, 0, 16'h4321, 4'h0, 4'h0};
    tbl[7]  = '{4'hB, BBL, 4,  0, 0, 16'h4321, 4'h0, 4'h0};
    tbl[8]  = '{4'h7, BER, 4,  1, 0, 16'hEF21, 4'h4, 4'h8};
    // too short, and two selects low
    tbl[9]  = '{4'hE, B5,  3,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[10] = '{4'hD, B6,  3,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[11] = '{4'hB, B7,  3,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[12] = '{4'h7, B8,  3,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[13] = '{4'hC, B8,  10, 0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[14] = '{4'hF, BBL, 2,  0, 0, 16'hEF21, 4'h4, 4'h8};
    // partial frame then timeout at exactly the 16th idle edge
    tbl[15] = '{4'hE, B0,  4,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[16] = '{4'hD, B9,  4,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[17] = '{4'hF, BBL, 15, 0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[18] = '{4'hF, BBL, 1,  0, 1, 16'hEF21, 4'h4, 4'h8};
    // normal frame afterwards
    tbl[19] = '{4'hE, B3,  4,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[20] = '{4'hD, B5,  4,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[21] = '{4'hB, B7,  4,  0, 0, 16'hEF21, 4'h4, 4'h8};
    tbl[22] = '{4'h7, B9,  4,  1, 0, 16'h9753, 4'h0, 4'h0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 16'h0000, 4'h0, 4'h0);
    chk("reset.valid", {15'h0, valid}, 16'h0);
    chk("reset.timeout", {15'h0, timeout}, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      seg(tbl[i].an, tbl[i].bcn, tbl[i].ncyc, nv, nt);
      chk($sformatf("row%0d.valid_cnt", i), 16'(nv), 16'(tbl[i].ev));
      chk($sformatf("row%0d.timeout_cnt", i), 16'(nt), 16'(tbl[i].et));
      chk_out($sformatf("row%0d", i), tbl[i].d, tbl[i].b, tbl[i].e);
    end

    // long hold: one capture only, so exactly one timeout 16 edges later
    seg(4'hE, B0, 100, nv, nt);
    chk("hold100.valid_cnt", 16'(nv), 16'd0);
    chk("hold100.timeout_cnt", 16'(nt), 16'd1);
    chk_out("hold100", 16'h9753, 4'h0, 4'h0);

    // build slots 1,2 then reset mid-frame
    av = 0; at = 0;
    seg(4'hD, B1, 4, nv, nt); av += nv; at += nt;
    seg(4'hB, B2, 4, nv, nt); av += nv; at += nt;
    seg(4'h7, B3, 2, nv, nt); av += nv; at += nt;
    rst = 1'b1;
    seg(4'h7, B3, 1, nv, nt); av += nv; at += nt;
    rst = 1'b0;
    chk("midrst.valid_cnt", 16'(av), 16'd0);
    chk("midrst.timeout_cnt", 16'(at), 16'd0);
    chk_out("midrst", 16'h0000, 4'h0, 4'h0);

    // slots 1,2 must be forgotten: capturing 3 and 0 does not complete a frame
    av = 0; at = 0;
    seg(4'h7, B3, 4, nv, nt); av += nv; at += nt;
    seg(4'hE, B4, 4, nv, nt); av += nv; at += nt;
    chk("postrst.valid_cnt", 16'(av), 16'd0);
    chk("postrst.timeout_cnt", 16'(at), 16'd0);
    chk_out("postrst", 16'h0000, 4'h0, 4'h0);

    rst = 1'b1;
    seg(4'hF, BBL, 1, nv, nt);
    rst = 1'b0;

    // last capture lands on the 16th idle edge: capture wins
    av = 0; at = 0;
    seg(4'hE, B6, 4, nv, nt);   av += nv; at += nt;
    seg(4'hD, B8, 4, nv, nt);   av += nv; at += nt;
    seg(4'hB, B0, 4, nv, nt);   av += nv; at += nt;
    seg(4'hF, BBL, 12, nv, nt); av += nv; at += nt;
    chk("race.pre_valid_cnt", 16'(av), 16'd0);
    chk("race.pre_timeout_cnt", 16'(at), 16'd0);
    for (int k = 1; k <= 4; k++) begin
      an  = 4'h7;
      bcn = B2;
      @(posedge clk);
      #1;
      chk($sformatf("race.edge%0d.valid", k), {15'h0, valid}, (k == 4) ? 16'd1 : 16'd0);
      chk($sformatf("race.edge%0d.timeout", k), {15'h0, timeout}, 16'd0);
    end
    chk_out("race", 16'h2086, 4'h0, 4'h0);
    seg(4'h7, B2, 20, nv, nt);
    chk("race.after_valid_cnt", 16'(nv), 16'd0);
    chk("race.after_timeout_cnt", 16'(nt), 16'd0);
    chk_out("race.after", 16'h2086, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
